vga_sync_gen: RTL and testbench

Free-running VGA timing generator that produces the HSync/VSync pair and the matching column/row position consumed by the game's sync-to-count and rendering logic. It is the transmitting end of the sync interface that the game top receives. It sits at the top level between the pixel clock and the frogger game and pattern blocks. Default timing is 640x480 at 60 Hz on an 800x525 total raster.

---
 rtl/vga_sync_gen.sv | 108 ++++++++++
 tb/tb_vga_sync_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing: registered col/row, active-low syncs, active flag and frame-start pulse.
// Frame counter register is built only when VGA_FRAME_COUNT_EN is defined; otherwise o_Frame_Count is 0.
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Pixel_En,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic [9:0]  o_Col_Count,
  output logic [9:0]  o_Row_Count,
  output logic        o_Active,
  output logic        o_Frame_Start,
  output logic [15:0] o_Frame_Count
);

  if ((ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) ||
      (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) ||
      (TOTAL_COLS > 1024) || (TOTAL_ROWS > 1024)) begin : g_bad_params
    $error("vga_sync_gen: inconsistent raster timing parameters");
  end

  // 11-bit bounds so a 1024-wide raster still compares correctly.
  localparam logic [9:0]  COL_LAST     = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  ROW_LAST     = 10'(TOTAL_ROWS - 1);
  localparam logic [10:0] H_ACT_END    = 11'(ACTIVE_COLS);
  localparam logic [10:0] V_ACT_END    = 11'(ACTIVE_ROWS);
  localparam logic [10:0] H_SYNC_START = 11'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [10:0] H_SYNC_END   = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [10:0] V_SYNC_START = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [10:0] V_SYNC_END   = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       frame_start_q, frame_start_d;
  logic [10:0] col_x, row_x;

  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = 10'd0;
      row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
    end
    col_x         = {1'b0, col_d};
    row_x         = {1'b0, row_d};
    hsync_d       = !((col_x >= H_SYNC_START) && (col_x < H_SYNC_END));
    vsync_d       = !((row_x >= V_SYNC_START) && (row_x < V_SYNC_END));
    active_d      = (col_x < H_ACT_END) && (row_x < V_ACT_END);
    frame_start_d = (col_d == 10'd0) && (row_d == 10'd0);
  end

  // Decode is done on the next position so every output matches the count it is registered with.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      col_q         <= COL_LAST;
      row_q         <= ROW_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (i_Pixel_En) begin
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      frame_cnt_q <= 16'd0;
    end else if (i_Pixel_En && frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_Frame_Count = frame_cnt_q;
`else
  assign o_Frame_Count = 16'd0;
`endif

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Active      = active_q;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 800x525 instance for line-level timing and a small raster
// instance so whole-frame, mid-frame reset and frame-count behaviour fit in a short run.
module tb_vga_sync_gen;

  logic       clk;
  logic [1:0] rst_n;
  logic [1:0] en;
  logic       hs  [2];
  logic       vs  [2];
  logic [9:0] col [2];
  logic [9:0] row [2];
  logic       act [2];
  logic       fs  [2];
  logic [15:0] fc [2];

  int checks   = 0;
  int failures = 0;

`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  // Raster geometry per instance: 0 = VGA defaults, 1 = small raster.
  localparam int TC [2]  = '{800, 20};
  localparam int TR [2]  = '{525, 12};
  localparam int AC [2]  = '{640, 12};
  localparam int AR [2]  = '{480, 8};
  localparam int HFP [2] = '{16, 2};
  localparam int HSW [2] = '{96, 3};
  localparam int VFP [2] = '{10, 1};
  localparam int VSW [2] = '{2, 2};

  vga_sync_gen dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n[0]), .i_Pixel_En(en[0]),
    .o_HSync(hs[0]), .o_VSync(vs[0]), .o_Col_Count(col[0]), .o_Row_Count(row[0]),
    .o_Active(act[0]), .o_Frame_Start(fs[0]), .o_Frame_Count(fc[0])
  );

  vga_sync_gen #(
    .TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(12), .ACTIVE_ROWS(8),
    .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2)
  ) dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n[1]), .i_Pixel_En(en[1]),
    .o_HSync(hs[1]), .o_VSync(vs[1]), .o_Col_Count(col[1]), .o_Row_Count(row[1]),
    .o_Active(act[1]), .o_Frame_Start(fs[1]), .o_Frame_Count(fc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s inst%0d: got %0d expected %0d", nm, k, actual, expected);
    end
  endtask

  // Model: raster position as a linear pixel index within the frame.
  int m_p   [2];
  int m_fc  [2];
  bit m_rst [2];
  bit m_fs  [2];
  bit m_vld [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        m_p[k]   = TC[k] * TR[k] - 1;
        m_rst[k] = 1'b1;
        m_fs[k]  = 1'b0;
        m_fc[k]  = 0;
        m_vld[k] = 1'b1;
      end else if (m_vld[k] && en[k]) begin
        m_p[k]   = (m_p[k] + 1) % (TC[k] * TR[k]);
        m_rst[k] = 1'b0;
        m_fs[k]  = (m_p[k] == 0);
        if (m_fs[k]) m_fc[k] = (m_fc[k] + 1) % 65536;
      end else begin
        m_fs[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_vld[k]) begin
        int c, r, hs_lo, vs_lo;
        c = m_p[k] % TC[k];
        r = m_p[k] / TC[k];
        hs_lo = (c >= AC[k] + HFP[k]) && (c < AC[k] + HFP[k] + HSW[k]);
        vs_lo = (r >= AR[k] + VFP[k]) && (r < AR[k] + VFP[k] + VSW[k]);
        chk("m_col", k, int'(col[k]), c);
        chk("m_row", k, int'(row[k]), r);
        chk("m_hsync", k, int'(hs[k]), m_rst[k] ? 1 : int'(!hs_lo));
        chk("m_vsync", k, int'(vs[k]), m_rst[k] ? 1 : int'(!vs_lo));
        chk("m_active", k, int'(act[k]), m_rst[k] ? 0 : int'((c < AC[k]) && (r < AR[k])));
        chk("m_fstart", k, int'(fs[k]), int'(m_fs[k]));
        chk("m_fcount", k, int'(fc[k]), FC_ON ? m_fc[k] : 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int lo, first, last, vlo, vmin, vmax, bad_act, prev_fs;
    rst_n = 2'b00;
    en    = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_col", 0, int'(col[0]), 799);
    chk("rst_row", 0, int'(row[0]), 524);
    chk("rst_hsync", 0, int'(hs[0]), 1);
    chk("rst_vsync", 0, int'(vs[0]), 1);
    chk("rst_active", 0, int'(act[0]), 0);
    chk("rst_fstart", 0, int'(fs[0]), 0);
    chk("rst_fcount", 0, int'(fc[0]), 0);
    rst_n = 2'b11;

    @(negedge clk);
    chk("first_col", 0, int'(col[0]), 0);
    chk("first_row", 0, int'(row[0]), 0);
    chk("first_active", 0, int'(act[0]), 1);
    chk("first_fstart", 0, int'(fs[0]), 1);

    lo = 0; first = -1; last = -1;
    for (int i = 1; i < 800; i++) begin
      @(negedge clk);
      if (col[0] == 10'd639) chk("active_col639", 0, int'(act[0]), 1);
      if (col[0] == 10'd640) chk("active_col640", 0, int'(act[0]), 0);
      if (!hs[0]) begin
        lo++;
        if (first < 0) first = int'(col[0]);
        last = int'(col[0]);
      end
    end
    chk("line_end_col", 0, int'(col[0]), 799);
    chk("hsync_low_cycles", 0, lo, 96);
    chk("hsync_first_col", 0, first, 656);
    chk("hsync_last_col", 0, last, 751);
    @(negedge clk);
    chk("wrap_col", 0, int'(col[0]), 0);
    chk("wrap_row", 0, int'(row[0]), 1);

    repeat (100) @(negedge clk);
    chk("pre_hold_col", 0, int'(col[0]), 100);
    en[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_col", 0, int'(col[0]), 100);
      chk("hold_row", 0, int'(row[0]), 1);
      chk("hold_hsync", 0, int'(hs[0]), 1);
      chk("hold_active", 0, int'(act[0]), 1);
      chk("hold_fstart", 0, int'(fs[0]), 0);
    end
    en[0] = 1'b1;
    @(negedge clk);
    chk("resume_col", 0, int'(col[0]), 101);

    // Small raster: clean restart, then three whole frames (240 cycles each).
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    vlo = 0; vmin = 99; vmax = -1; bad_act = 0; prev_fs = -1;
    for (int i = 0; i < 720; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("s_first_col", 1, int'(col[1]), 0);
        chk("s_first_fstart", 1, int'(fs[1]), 1);
      end
      if (!vs[1]) begin
        vlo++;
        if (int'(row[1]) < vmin) vmin = int'(row[1]);
        if (int'(row[1]) > vmax) vmax = int'(row[1]);
      end
      if (act[1] && row[1] >= 10'd8) bad_act++;
      if (fs[1]) begin
        if (prev_fs >= 0) chk("fstart_spacing", 1, i - prev_fs, 240);
        prev_fs = i;
      end
    end
    chk("vsync_low_cycles", 1, vlo, 120);
    chk("vsync_first_row", 1, vmin, 9);
    chk("vsync_last_row", 1, vmax, 10);
    chk("active_in_vblank", 1, bad_act, 0);
    chk("last_fstart_idx", 1, prev_fs, 480);
    chk("fcount_3frames", 1, int'(fc[1]), FC_ON ? 3 : 0);

    // Pending frame start survives an enable gap at the last raster position.
    chk("gap_col", 1, int'(col[1]), 19);
    en[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gap_fstart", 1, int'(fs[1]), 0);
      chk("gap_row", 1, int'(row[1]), 11);
    end
    en[1] = 1'b1;
    @(negedge clk);
    chk("gap_resume_col", 1, int'(col[1]), 0);
    chk("gap_resume_fstart", 1, int'(fs[1]), 1);

    // Mid-frame reset at row 5, col 7.
    repeat (107) @(negedge clk);
    chk("mid_col", 1, int'(col[1]), 7);
    chk("mid_row", 1, int'(row[1]), 5);
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("mrst_col", 1, int'(col[1]), 19);
    chk("mrst_row", 1, int'(row[1]), 11);
    chk("mrst_hsync", 1, int'(hs[1]), 1);
    chk("mrst_vsync", 1, int'(vs[1]), 1);
    chk("mrst_active", 1, int'(act[1]), 0);
    chk("mrst_fstart", 1, int'(fs[1]), 0);
    chk("mrst_fcount", 1, int'(fc[1]), 0);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("mrst_next_col", 1, int'(col[1]), 0);
    chk("mrst_next_row", 1, int'(row[1]), 0);
    chk("mrst_next_fstart", 1, int'(fs[1]), 1);
    chk("mrst_next_fcount", 1, int'(fc[1]), FC_ON ? 1 : 0);

`ifdef VGA_FRAME_COUNT_EN
    dut1.frame_cnt_q = 16'hFFFE;
    m_fc[1] = 65534;
`endif
    repeat (240) @(negedge clk);
    chk("fcount_near_wrap", 1, int'(fc[1]), FC_ON ? 65535 : 0);
    repeat (240) @(negedge clk);
    chk("fcount_wrapped", 1, int'(fc[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
